// File: rtl/dll_rx_ack_nak_pkg.sv
// Shared data-link definitions: sequence width, DLLP encodings, FSM states.
// seq_dist is also used by the transmit replay buffer.
package dll_pkg;

  localparam int SEQ_W = 12;

  localparam logic [1:0] DLLP_NONE = 2'b00;
  localparam logic [1:0] DLLP_ACK  = 2'b01;
  localparam logic [1:0] DLLP_NAK  = 2'b10;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_ACK = 2'd1,
    SEND_NAK = 2'd2
  } dllp_state_e;

  // Forward distance from b to a, modulo 2**SEQ_W.
  function automatic seq_t seq_dist(input seq_t a, input seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/dll_rx_ack_nak_if.sv
// Receive-side TLP status and ACK/NAK DLLP request bundle.
// The engine sits on the slave side; the link layer or bench drives master.
interface dll_rx_ack_nak_if;
  import dll_pkg::*;

  logic       tlp_valid;
  seq_t       tlp_seq;
  logic       tlp_lcrc_ok;
  logic       tlp_accept;
  logic       tlp_drop;
  logic       dllp_valid;
  logic       dllp_ready;
  logic [1:0] dllp_type;
  seq_t       dllp_seq;
  seq_t       next_rcv_seq;

  modport master (
    output tlp_valid, tlp_seq, tlp_lcrc_ok, dllp_ready,
    input  tlp_accept, tlp_drop, dllp_valid, dllp_type, dllp_seq, next_rcv_seq
  );

  modport slave (
    input  tlp_valid, tlp_seq, tlp_lcrc_ok, dllp_ready,
    output tlp_accept, tlp_drop, dllp_valid, dllp_type, dllp_seq, next_rcv_seq
  );

endinterface

// File: rtl/dll_rx_ack_nak_classify.sv
// Combinational TLP classifier: in-order accept, duplicate, lost (gap) or bad LCRC.
module dll_seq_classify
  import dll_pkg::*;
(
  input  seq_t i_seq,
  input  seq_t i_nrs,
  input  logic i_lcrc_ok,
  output logic o_accept,
  output logic o_dup,
  output logic o_lost,
  output logic o_bad
);

  seq_t w_dist;

  assign w_dist = seq_dist(i_seq, i_nrs);

  // Upper half of the sequence space counts as "behind" nrs, i.e. already received.
  assign o_bad    = ~i_lcrc_ok;
  assign o_accept = i_lcrc_ok & (w_dist == '0);
  assign o_dup    = i_lcrc_ok & w_dist[SEQ_W-1];
  assign o_lost   = i_lcrc_ok & (w_dist != '0) & ~w_dist[SEQ_W-1];

endmodule

// File: rtl/dll_rx_ack_nak.sv
// Receive-side ACK/NAK engine: tracks NEXT_RCV_SEQ, forwards in-order TLPs,
// and schedules ACK/NAK DLLPs for the remote replay buffer.
module dll_rx_ack_nak
  import dll_pkg::*;
#(
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  dll_rx_ack_nak_if.slave  bus
);

  localparam int PEND_W = $clog2(ACK_COALESCE + 1);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(ACK_COALESCE);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  dllp_state_e       r_state, w_state_next;
  seq_t              r_nrs, w_nrs_next;
  seq_t              r_dllp_seq;
  logic              r_nak_sched, r_req_ack, r_req_nak;
  logic              r_accept, r_drop;
  logic [PEND_W-1:0] r_pending;
  logic [TMR_W-1:0]  r_timer;

  logic w_c_accept, w_c_dup, w_c_lost, w_c_bad;
  logic w_acc, w_dup, w_nak_set, w_ack_cond, w_req_ack, w_issue;
  logic w_dllp_valid;
  logic [1:0] w_dllp_type;

  dll_seq_classify u_classify (
    .i_seq     (bus.tlp_seq),
    .i_nrs     (r_nrs),
    .i_lcrc_ok (bus.tlp_lcrc_ok),
    .o_accept  (w_c_accept),
    .o_dup     (w_c_dup),
    .o_lost    (w_c_lost),
    .o_bad     (w_c_bad)
  );

  assign w_acc      = bus.tlp_valid & w_c_accept;
  assign w_dup      = bus.tlp_valid & w_c_dup;
  assign w_nak_set  = bus.tlp_valid & (w_c_lost | w_c_bad) & ~r_nak_sched;
  assign w_nrs_next = w_acc ? r_nrs + SEQ_W'(1) : r_nrs;
  // The ACK trigger is seen by the FSM directly so a timeout ACK issues on the boundary cycle.
  assign w_ack_cond = (r_pending >= PEND_MAX) || ((r_pending != '0) && (r_timer == TMR_LAST));
  assign w_req_ack  = r_req_ack | w_ack_cond;
  assign w_issue    = (r_state == IDLE) && (w_state_next != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_req_nak)      w_state_next = SEND_NAK;
        else if (w_req_ack) w_state_next = SEND_ACK;
      end
      SEND_ACK, SEND_NAK: begin
        if (bus.dllp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_dllp_valid = 1'b0;
    w_dllp_type  = DLLP_NONE;
    case (r_state)
      SEND_ACK: begin
        w_dllp_valid = 1'b1;
        w_dllp_type  = DLLP_ACK;
      end
      SEND_NAK: begin
        w_dllp_valid = 1'b1;
        w_dllp_type  = DLLP_NAK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nrs       <= '0;
      r_nak_sched <= 1'b0;
      r_req_ack   <= 1'b0;
      r_req_nak   <= 1'b0;
      r_pending   <= '0;
      r_timer     <= '0;
      r_dllp_seq  <= '0;
      r_accept    <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_accept <= w_acc;
      r_drop   <= bus.tlp_valid & ~w_c_accept;
      r_nrs    <= w_nrs_next;

      if (w_acc)          r_nak_sched <= 1'b0;
      else if (w_nak_set) r_nak_sched <= 1'b1;

      // An accept coinciding with an issue starts the next pending window.
      if (w_issue) begin
        r_dllp_seq <= w_nrs_next - SEQ_W'(1);
        r_pending  <= w_acc ? PEND_W'(1) : '0;
        r_timer    <= '0;
      end else begin
        if (w_acc && (r_pending != PEND_MAX)) r_pending <= r_pending + PEND_W'(1);
        if (r_pending == '0)                  r_timer   <= '0;
        else if (r_timer != TMR_LAST)         r_timer   <= r_timer + TMR_W'(1);
      end

      if (w_issue && (w_state_next == SEND_NAK)) r_req_nak <= w_nak_set;
      else if (w_nak_set)                        r_req_nak <= 1'b1;

      // A NAK acknowledges everything before it, so it absorbs any ACK request.
      if (w_issue)                  r_req_ack <= w_dup;
      else if (w_dup || w_ack_cond) r_req_ack <= 1'b1;
    end
  end

  assign bus.tlp_accept   = r_accept;
  assign bus.tlp_drop     = r_drop;
  assign bus.dllp_valid   = w_dllp_valid;
  assign bus.dllp_type    = w_dllp_type;
  assign bus.dllp_seq     = r_dllp_seq;
  assign bus.next_rcv_seq = r_nrs;

endmodule
